mem_bist_ctrl: RTL
==================

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 Parameter: ADDR_W, 5, memory address width; depth = 2^ADDR_W words (32).
REQ-002 Parameter: DATA_W, 32, memory word width.
REQ-003 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  test request; sampled only in IDLE.
REQ-006 Port: pattern  input  DATA_W  background pattern P; captured when start is accepted.
REQ-007 Port: mem_data_out  output  DATA_W  write data to memory data_in.
REQ-008 Port: mem_address  output  ADDR_W  memory address.
REQ-009 Port: mem_read_en  output  1  memory read enable.
REQ-010 Port: mem_write_en  output  1  memory write enable.
REQ-011 Port: mem_data_in  input  DATA_W  memory data_out; valid the cycle after mem_read_en is high.
REQ-012 Port: busy  output  1  test in progress.
REQ-013 Port: done  output  1  one-cycle completion pulse.
REQ-014 Port: pass  output  1  last test found no mismatch; held until next accepted start.
REQ-015 Port: fail_addr / fail_exp / fail_act  output  ADDR_W / DATA_W / DATA_W  first-mismatch capture.

Function
REQ-016 States: IDLE, W0, R0_RD, R0_CHK, R1_RD, R1_CHK, DONE.
REQ-017 IDLE: start=1 -> capture P, clear pass and fail_*, address counter=0, next state W0; start while busy is ignored.
REQ-018 W0 (ascending 0..31): mem_write_en=1, mem_data_out=P, one address per cycle; after address 31 -> R0_RD, counter=0.
REQ-019 R0_RD: mem_read_en=1 at counter -> R0_CHK.
REQ-020 R0_CHK: compare mem_data_in to P; match -> mem_write_en=1, mem_data_out=~P at same address, counter+1, back to R0_RD; after address 31 -> R1_RD, counter=31.
REQ-021 R1_RD / R1_CHK (descending 31..0): read, then compare to ~P with no write; after address 0 -> DONE.
REQ-022 Each read or check phase uses exactly 2 cycles per address; fault-free run is 32+64+64 = 160 busy cycles, first W0 cycle is the cycle after start is sampled.
REQ-023 Mismatch in any CHK state: no write that cycle, latch fail_addr=counter, fail_exp, fail_act=mem_data_in, abort -> DONE next cycle; only the first mismatch is recorded.
REQ-024 DONE: done=1 for exactly one cycle, pass=1 if no mismatch, busy=0 -> IDLE.
REQ-025 busy=1 in every state except IDLE and DONE.
REQ-026 mem_read_en and mem_write_en are never high in the same cycle; both are 0 in IDLE, DONE, R1_CHK.
REQ-027 mem_address and mem_data_out are 0 whenever neither enable is high.
REQ-028 Counter wraps are never used: ascending stops at 31, descending stops at 0.

Reset
REQ-029 reset=1 at a clock edge -> IDLE regardless of state, including mid-test.
REQ-030 Reset values: all mem_* outputs 0, busy=0, done=0, pass=0, fail_addr=0, fail_exp=0, fail_act=0, captured P=0.
REQ-031 An aborted test leaves the memory contents undefined; no completion pulse is issued.

Verification
REQ-032 Fault-free 32x32 memory model, P=0xA5A5A5A5, start one cycle -> busy for 160 cycles, done pulse in cycle 161, pass=1, fail_* = 0.
REQ-033 Model with bit 3 stuck-at-0 at address 7, P=0xFFFFFFFF -> abort in R0_CHK at address 7: fail_addr=7, fail_exp=0xFFFFFFFF, fail_act=0xFFFFFFF7, pass=0, done one cycle later.
REQ-034 Model with bit 0 stuck-at-1 at address 31, P=0xFFFFFFFE -> R0 fails at address 31: fail_exp=0xFFFFFFFE, fail_act=0xFFFFFFFF; with P=0x00000001 R0 passes, R1 fails at address 31: fail_exp=0xFFFFFFFE, fail_act=0xFFFFFFFF.
REQ-035 Pulse start again at cycles 10 and 100 of a running test -> ignored; completion timing identical to REQ-032.
REQ-036 reset=1 at busy cycle 50 -> next cycle all outputs at reset values, state IDLE; new start then runs full REQ-032 sequence with pass=1.
REQ-037 Assertion throughout all runs: mem_read_en and mem_write_en never both 1; done never high for two consecutive cycles.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - three-pass march BIST controller for a single-port RAM
//
// Sequence: ascending write P, ascending read-check P then write ~P,
// descending read-check ~P. Aborts on the first mismatch.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   start, pattern      test request (sampled in idle) and background pattern P
//   mem_data_out        write data to the memory
//   mem_address         memory address
//   mem_read_en         memory read enable (read data returns next cycle)
//   mem_write_en        memory write enable
//   mem_data_in         memory read data
//   busy, done, pass    status; done is a one-cycle pulse, pass is held
//   fail_addr/exp/act   first-mismatch capture
module mem_bist_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] pattern,
   output logic [DATA_W-1:0] mem_data_out,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read_en,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_exp,
   output logic [DATA_W-1:0] fail_act
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
   localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

   typedef enum logic [2:0] {
      s_idle,
      s_w0,
      s_r0_rd,
      s_r0_chk,
      s_r1_rd,
      s_r1_chk,
      s_done
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] pat;
   logic [DATA_W-1:0] exp_word;
   logic              mismatch;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= s_idle;
      end else begin
         state <= state_next;
      end
   end

   // The check phase of the descending pass expects the inverted background
   // written during the ascending read pass.
   assign exp_word = (state == s_r1_chk) ? ~pat : pat;

   always_comb begin
      state_next   = state;
      mem_data_out = '0;
      mem_address  = '0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      mismatch     = 1'b0;
      case (state)
         s_idle: begin
            if (start) begin
               state_next = s_w0;
            end
         end
         s_w0: begin
            busy         = 1'b1;
            mem_write_en = 1'b1;
            mem_address  = cnt;
            mem_data_out = pat;
            if (cnt == LAST_ADDR) begin
               state_next = s_r0_rd;
            end
         end
         s_r0_rd: begin
            busy        = 1'b1;
            mem_read_en = 1'b1;
            mem_address = cnt;
            state_next  = s_r0_chk;
         end
         s_r0_chk: begin
            busy = 1'b1;
            if (mem_data_in != exp_word) begin
               // No write-back on a mismatch, so the faulty cell is left as read.
               mismatch   = 1'b1;
               state_next = s_done;
            end else begin
               mem_write_en = 1'b1;
               mem_address  = cnt;
               mem_data_out = ~pat;
               state_next   = (cnt == LAST_ADDR) ? s_r1_rd : s_r0_rd;
            end
         end
         s_r1_rd: begin
            busy        = 1'b1;
            mem_read_en = 1'b1;
            mem_address = cnt;
            state_next  = s_r1_chk;
         end
         s_r1_chk: begin
            busy = 1'b1;
            if (mem_data_in != exp_word) begin
               mismatch   = 1'b1;
               state_next = s_done;
            end else begin
               state_next = (cnt == ZERO_ADDR) ? s_done : s_r1_rd;
            end
         end
         s_done: begin
            done       = 1'b1;
            state_next = s_idle;
         end
         default: begin
            state_next = s_idle;
         end
      endcase
   end

   // Address counter, pattern capture and result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt       <= '0;
         pat       <= '0;
         pass      <= 1'b0;
         fail_addr <= '0;
         fail_exp  <= '0;
         fail_act  <= '0;
      end else begin
         case (state)
            s_idle: begin
               if (start) begin
                  cnt       <= '0;
                  pat       <= pattern;
                  pass      <= 1'b0;
                  fail_addr <= '0;
                  fail_exp  <= '0;
                  fail_act  <= '0;
               end
            end
            s_w0: begin
               // Restart at 0 for the read pass rather than relying on wrap.
               cnt <= (cnt == LAST_ADDR) ? ZERO_ADDR : cnt + ONE_ADDR;
            end
            s_r0_chk: begin
               // At the top address the counter stays put: the descending
               // pass begins at the same address.
               if (!mismatch && cnt != LAST_ADDR) begin
                  cnt <= cnt + ONE_ADDR;
               end
            end
            s_r1_chk: begin
               if (!mismatch) begin
                  if (cnt == ZERO_ADDR) begin
                     pass <= 1'b1;
                  end else begin
                     cnt <= cnt - ONE_ADDR;
                  end
               end
            end
            default: begin
            end
         endcase
         if (mismatch) begin
            fail_addr <= cnt;
            fail_exp  <= exp_word;
            fail_act  <= mem_data_in;
         end
      end
   end

endmodule
